muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide execute unit, directly downstream of the register file.
- Consumes the rs1/rs2 read data and produces a 32-bit writeback result with its destination register tag.
- Holds `busy` while computing, so the core stalls fetch/decode and suppresses its regfile write until `done`.
- One multiply or divide in flight at a time.

---
 rtl/muldiv_unit.sv | 147 ++++++++++++++
 tb/tb_muldiv_unit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide execute unit
// Shift-add multiply and restoring divide on operand magnitudes, one radix-2 step per cycle.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t            r_state, w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_op;
    logic [4:0]        r_rd;
    logic [4:0]        r_rd_out;
    logic              r_neg_a, r_neg_b;
    logic [XLEN-1:0]   r_b;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_result;

    logic              w_a_signed, w_b_signed, w_a_neg, w_b_neg;
    logic [XLEN-1:0]   w_a_mag, w_b_mag;
    logic              w_div_zero, w_div_ovf, w_special;
    logic [XLEN-1:0]   w_special_res;
    logic              w_last;
    logic [XLEN:0]     w_mul_sum, w_trial, w_diff;
    logic [2*XLEN-1:0] w_mul_next, w_div_next, w_acc_next, w_prod;
    logic [XLEN-1:0]   w_quo, w_rem, w_final;

    // Signedness decoded from funct3: MUL/MULH/DIV/REM signed both, MULHSU signed rs1 only.
    assign w_a_signed = (!op[2] && (op != 3'd3)) || (op[2] && !op[0]);
    assign w_b_signed = (!op[2] && !op[1]) || (op[2] && !op[0]);
    assign w_a_neg    = w_a_signed && rs1_data[XLEN-1];
    assign w_b_neg    = w_b_signed && rs2_data[XLEN-1];
    assign w_a_mag    = w_a_neg ? (~rs1_data + 1'b1) : rs1_data;
    assign w_b_mag    = w_b_neg ? (~rs2_data + 1'b1) : rs2_data;

    assign w_div_zero    = op[2] && (rs2_data == '0);
    assign w_div_ovf     = op[2] && !op[0] && (rs1_data == {1'b1, {(XLEN-1){1'b0}}})
                           && (rs2_data == '1);
    assign w_special     = w_div_zero || w_div_ovf;
    assign w_special_res = w_div_zero ? (op[1] ? rs1_data : '1)
                                      : (op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});

    assign w_last = (r_cnt == CNT_W'(XLEN-1));

    // Multiply: accumulator high half gathers partial sums, low half shifts the multiplier out.
    assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};

    // Divide: high half is the partial remainder, low half shifts dividend out and quotient in.
    assign w_trial    = r_acc[2*XLEN-1:XLEN-1];
    assign w_diff     = w_trial - {1'b0, r_b};
    assign w_div_next = w_diff[XLEN] ? {w_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                                     : {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
    assign w_acc_next = r_op[2] ? w_div_next : w_mul_next;

    assign w_prod = (r_neg_a ^ r_neg_b) ? (~w_acc_next + 1'b1) : w_acc_next;
    assign w_quo  = (r_neg_a ^ r_neg_b) ? (~w_acc_next[XLEN-1:0] + 1'b1) : w_acc_next[XLEN-1:0];
    assign w_rem  = r_neg_a ? (~w_acc_next[2*XLEN-1:XLEN] + 1'b1) : w_acc_next[2*XLEN-1:XLEN];

    always_comb begin
        w_final = '0;
        case (r_op)
            3'd0:                w_final = w_prod[XLEN-1:0];
            3'd1, 3'd2, 3'd3:    w_final = w_prod[2*XLEN-1:XLEN];
            3'd4, 3'd5:          w_final = w_quo;
            default:             w_final = w_rem;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = w_special ? S_DONE : S_CALC;
            S_CALC:  if (w_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state != S_IDLE);
        done = (r_state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_op     <= '0;
            r_rd     <= '0;
            r_rd_out <= '0;
            r_neg_a  <= 1'b0;
            r_neg_b  <= 1'b0;
            r_b      <= '0;
            r_acc    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_op    <= op;
                    r_rd    <= rd_in;
                    r_neg_a <= w_a_neg;
                    r_neg_b <= w_b_neg;
                    r_cnt   <= '0;
                    if (w_special) begin
                        r_result <= w_special_res;
                        r_rd_out <= rd_in;
                    end else if (op[2]) begin
                        r_acc <= {{XLEN{1'b0}}, w_a_mag};
                        r_b   <= w_b_mag;
                    end else begin
                        r_acc <= {{XLEN{1'b0}}, w_b_mag};
                        r_b   <= w_a_mag;
                    end
                end
                S_CALC: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_result <= w_final;
                        r_rd_out <= r_rd;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result = r_result;
    assign rd_out = r_rd_out;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit
// Directed RV32M cases plus random ops against a 64-bit arithmetic reference model.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic [4:0]  rd_in = '0;
    logic        busy, done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int checks = 0;
    int errors = 0;

    muldiv_unit dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_in(rd_in),
        .busy(busy), .done(done), .result(result), .rd_out(rd_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sp;
        logic [63:0] up;
        case (o)
            3'd0: begin sp = longint'($signed(a)) * longint'($signed(b)); return sp[31:0]; end
            3'd1: begin sp = longint'($signed(a)) * longint'($signed(b)); return sp[63:32]; end
            3'd2: begin sp = longint'($signed(a)) * longint'({32'b0, b}); return sp[63:32]; end
            3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                return $signed(a) / $signed(b);
            end
            3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                return $signed(a) % $signed(b);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic is_special(input logic [2:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
        return o[2] && (b == 0 || (!o[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h80000000;
            2:       return 32'hFFFFFFFF;
            3:       return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        @(negedge clk);
        start = 1'b1; op = o; rs1_data = a; rs2_data = b; rd_in = rd;
        @(posedge clk); #1;
        start = 1'b0; rs1_data = $urandom; rs2_data = $urandom; rd_in = 5'($urandom);
    endtask

    // Waits for done (bounded), starting in the cycle right after the start edge.
    task automatic wait_done(output int lat, output int busy_cnt);
        lat = 1; busy_cnt = 0;
        while (!done && lat < 40) begin
            if (busy) busy_cnt++;
            @(posedge clk); #1;
            lat++;
        end
        if (busy) busy_cnt++;
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd);
        int lat, bc;
        issue(o, a, b, rd);
        wait_done(lat, bc);
        chk({tag, "_lat"}, lat, is_special(o, a, b) ? 1 : 33);
        chk({tag, "_res"}, result, ref_model(o, a, b));
        chk({tag, "_rd"}, rd_out, rd);
        chk({tag, "_busy"}, bc, lat);
        @(posedge clk); #1;
        chk({tag, "_done_low"}, {busy, done}, 2'b00);
    endtask

    initial begin
        int lat, bc, pulses;
        logic [31:0] held;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_result", result, 32'h0);
        chk("reset_rd", rd_out, 5'h0);

        run_op("mul_7_m3", 3'd0, 32'd7, 32'hFFFFFFFD, 5'd5);
        chk("mul_7_m3_const", result, 32'hFFFFFFEB);
        run_op("mulh_min", 3'd1, 32'h80000000, 32'h80000000, 5'd1);
        chk("mulh_min_const", result, 32'h40000000);
        run_op("mulhu_ones", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2);
        chk("mulhu_ones_const", result, 32'hFFFFFFFE);
        run_op("mulhsu_ones", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3);
        chk("mulhsu_ones_const", result, 32'hFFFFFFFF);
        run_op("div_m7_2", 3'd4, 32'hFFFFFFF9, 32'd2, 5'd4);
        chk("div_m7_2_const", result, 32'hFFFFFFFD);
        run_op("rem_m7_2", 3'd6, 32'hFFFFFFF9, 32'd2, 5'd6);
        chk("rem_m7_2_const", result, 32'hFFFFFFFF);
        run_op("divu_100_7", 3'd5, 32'd100, 32'd7, 5'd7);
        chk("divu_100_7_const", result, 32'd14);
        run_op("remu_100_7", 3'd7, 32'd100, 32'd7, 5'd8);
        chk("remu_100_7_const", result, 32'd2);
        run_op("divu_by0", 3'd5, 32'd5, 32'd0, 5'd10);
        run_op("rem_by0", 3'd6, 32'd5, 32'd0, 5'd11);
        chk("rem_by0_const", result, 32'd5);
        run_op("div_ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd12);
        chk("div_ovf_const", result, 32'h80000000);
        run_op("rem_ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd0);

        // start pulse at counter 3 must be ignored
        issue(3'd5, 32'd100, 32'd7, 5'd3);
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        start = 1'b1; op = 3'd0; rs1_data = 32'd2; rs2_data = 32'd3; rd_in = 5'd9;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 5; pulses = 0;
        while (!done && lat < 40) begin @(posedge clk); #1; lat++; end
        chk("busy_start_lat", lat, 33);
        chk("busy_start_res", result, 32'd14);
        chk("busy_start_rd", rd_out, 5'd3);
        // start asserted in the DONE cycle must be ignored
        start = 1'b1; op = 3'd5; rs1_data = 32'd1; rs2_data = 32'd0; rd_in = 5'd9;
        @(posedge clk); #1;
        start = 1'b0;
        chk("done_start_busy", {busy, done}, 2'b00);
        repeat (5) begin
            if (done) pulses++;
            @(posedge clk); #1;
        end
        chk("single_done_pulse", pulses, 0);
        chk("done_start_res", result, 32'd14);
        run_op("after_done_accept", 3'd7, 32'd100, 32'd7, 5'd13);

        // reset mid-computation
        issue(3'd0, 32'd123, 32'd456, 5'd14);
        repeat (10) @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_state", {busy, done}, 2'b00);
        chk("midrst_result", result, 32'h0);
        chk("midrst_rd", rd_out, 5'h0);
        pulses = 0;
        repeat (30) begin
            if (done || busy) pulses++;
            @(posedge clk); #1;
        end
        chk("midrst_no_done", pulses, 0);
        run_op("mulhu_post_rst", 3'd3, 32'h10000, 32'h10000, 5'd15);
        chk("mulhu_post_rst_const", result, 32'h1);

        for (int i = 0; i < 24; i++) begin
            logic [2:0]  ro;
            logic [31:0] ra, rb;
            ro = 3'($urandom_range(0, 7));
            ra = pick();
            rb = pick();
            run_op($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb, 5'($urandom));
        end

        held = result;
        repeat (4) @(posedge clk);
        #1;
        chk("result_hold", result, held);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
